instr_fetch: RTL and testbench

//  Front-end fetch stage: loads PC from the reset vector, then reads opcode + 0..2 operand bytes

---
 rtl/instr_fetch_if.sv | 23 ++
 rtl/instr_fetch.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: 8-bit memory read port plus the instruction
// valid/ready handshake towards execute.
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_addr, mem_rd, opcode, operand, instr_pc, instr_valid,
        input  mem_data, mem_ready, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rd, opcode, operand, instr_pc, instr_valid,
        output mem_data, mem_ready, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads PC from the reset vector, then reads an
// opcode plus 0..2 operand bytes and presents the whole instruction to
// execute with a valid/ready handshake.
// Optional feature macro: INSTR_FETCH_PREFETCH_EN (1-byte opcode prefetch
// while waiting in HOLD).
module instr_fetch #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_if.master     bus,
    output logic [7:0]        dec_opcode_o,
    input  logic [1:0]        op_len_i,
    input  logic              pc_load_i,
    input  logic [15:0]       pc_load_val_i,
    output logic [15:0]       pc_o
);

    typedef enum logic [2:0] {RST_LO, RST_HI, OPC, OPR1, OPR2, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        rd_done;
    logic        len_le1;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic        buf_valid_q, buf_valid_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        hold_have;
    logic [7:0]  hold_byte;

    // Next opcode in HOLD comes from the buffer, or from a read completing now.
    assign hold_have = buf_valid_q || rd_done;
    assign hold_byte = buf_valid_q ? buf_data_q : bus.mem_data;
`endif

    assign rd_done = bus.mem_rd && bus.mem_ready;
    // A decoder length of 0 is treated like a 1-byte instruction.
    assign len_le1 = (op_len_i <= 2'd1);

    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign pc_o            = pc_q;

    // Bus address/strobe and the opcode shown to the decoder.
    always_comb begin
        bus.mem_addr = pc_q;
        bus.mem_rd   = !rst && (state_q != HOLD);
        dec_opcode_o = opcode_q;
        case (state_q)
            RST_LO: bus.mem_addr = RESET_VEC;
            RST_HI: bus.mem_addr = RESET_VEC + 16'd1;
            OPC:    dec_opcode_o = bus.mem_data;
`ifdef INSTR_FETCH_PREFETCH_EN
            HOLD: begin
                bus.mem_rd   = !rst && !buf_valid_q;
                dec_opcode_o = hold_byte;
            end
`endif
            default: ;
        endcase
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        instr_pc_d = instr_pc_q;
`ifdef INSTR_FETCH_PREFETCH_EN
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_pc_d    = buf_pc_q;
`endif
        if (pc_load_i && (state_q != RST_LO) && (state_q != RST_HI)) begin
            // Redirect wins over any read finishing this cycle.
            pc_d    = pc_load_val_i;
            state_d = OPC;
`ifdef INSTR_FETCH_PREFETCH_EN
            buf_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                RST_LO: if (rd_done) begin
                    pc_d[7:0] = bus.mem_data;
                    state_d   = RST_HI;
                end
                RST_HI: if (rd_done) begin
                    pc_d[15:8] = bus.mem_data;
                    state_d    = OPC;
                end
                OPC: if (rd_done) begin
                    opcode_d   = bus.mem_data;
                    instr_pc_d = pc_q;
                    operand_d  = 16'h0000;
                    pc_d       = pc_q + 16'd1;
                    state_d    = len_le1 ? HOLD : OPR1;
                end
                OPR1: if (rd_done) begin
                    operand_d[7:0] = bus.mem_data;
                    pc_d           = pc_q + 16'd1;
                    state_d        = (op_len_i == 2'd3) ? OPR2 : HOLD;
                end
                OPR2: if (rd_done) begin
                    operand_d[15:8] = bus.mem_data;
                    pc_d            = pc_q + 16'd1;
                    state_d         = HOLD;
                end
                HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                    if (bus.instr_ready) begin
                        buf_valid_d = 1'b0;
                        if (hold_have) begin
                            opcode_d   = hold_byte;
                            instr_pc_d = buf_valid_q ? buf_pc_q : pc_q;
                            operand_d  = 16'h0000;
                            pc_d       = pc_q + 16'd1;
                            state_d    = len_le1 ? HOLD : OPR1;
                        end else begin
                            state_d = OPC;
                        end
                    end else if (rd_done) begin
                        buf_valid_d = 1'b1;
                        buf_data_d  = bus.mem_data;
                        buf_pc_d    = pc_q;
                    end
`else
                    if (bus.instr_ready) state_d = OPC;
`endif
                end
                default: state_d = RST_LO;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_LO;
            pc_q       <= 16'h0000;
            opcode_q   <= 8'h00;
            operand_q  <= 16'h0000;
            instr_pc_q <= 16'h0000;
`ifdef INSTR_FETCH_PREFETCH_EN
            buf_valid_q <= 1'b0;
            buf_data_q  <= 8'h00;
            buf_pc_q    <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            instr_pc_q <= instr_pc_d;
`ifdef INSTR_FETCH_PREFETCH_EN
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_pc_q    <= buf_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory model, small decoder length
// table, hand-computed expected values.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dec_opcode;
    logic [1:0]  op_len;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc;
    logic [7:0]  mem [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_VEC(16'hFFFC)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dec_opcode_o  (dec_opcode),
        .op_len_i      (op_len),
        .pc_load_i     (pc_load),
        .pc_load_val_i (pc_load_val),
        .pc_o          (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] len_of(input logic [7:0] op);
        case (op)
            8'hEA:   return 2'd1;
            8'hA9:   return 2'd2;
            8'hAD:   return 2'd3;
            8'h4C:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    assign op_len       = len_of(dec_opcode);
    assign bus.mem_data = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_dut(input bit do_chk);
        rst           = 1'b1;
        pc_load       = 1'b0;
        pc_load_val   = 16'h0000;
        bus.mem_ready   = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        if (do_chk) begin
            chk("rst_valid", bus.instr_valid, 1'b0);
            chk("rst_rd", bus.mem_rd, 1'b0);
            chk("rst_pc", pc, 16'h0000);
            chk("rst_opcode", bus.opcode, 8'h00);
            chk("rst_operand", bus.operand, 16'h0000);
            chk("rst_ipc", bus.instr_pc, 16'h0000);
        end
        rst = 1'b0;
        #1;
        if (do_chk) begin
            chk("vec_addr", bus.mem_addr, 16'hFFFC);
            chk("vec_rd", bus.mem_rd, 1'b1);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]  e_op  [3] = '{8'hEA, 8'hAD, 8'hEA};
    logic [15:0] e_opr [3] = '{16'h0000, 16'h1234, 16'h0000};
    logic [15:0] e_ipc [3] = '{16'h8000, 16'h8001, 16'h8004};
`ifdef INSTR_FETCH_PREFETCH_EN
    int          e_cyc [3] = '{3, 6, 7};
`else
    int          e_cyc [3] = '{3, 7, 9};
`endif

    initial begin
        int got;
        bit rd_in_hold;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        // Test 1 + 3: vector fetch, 2-byte instr, stall with instr_ready low.
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'hEA;
        reset_dut(1'b1);
        cyc(3);
        chk("t1_valid_early", bus.instr_valid, 1'b0);
        chk("t1_opr1_addr", bus.mem_addr, 16'h8001);
        cyc(1);
        chk("t1_valid", bus.instr_valid, 1'b1);
        chk("t1_opcode", bus.opcode, 8'hA9);
        chk("t1_operand", bus.operand, 16'h0042);
        chk("t1_ipc", bus.instr_pc, 16'h8000);
        chk("t1_pc", pc, 16'h8002);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t3_hold_valid", bus.instr_valid, 1'b1);
            chk("t3_hold_opcode", {bus.opcode, bus.operand}, 24'hA90042);
`ifndef INSTR_FETCH_PREFETCH_EN
            chk("t3_hold_rd", bus.mem_rd, 1'b0);
`endif
        end
        bus.instr_ready = 1'b1;
        cyc(1);
        bus.instr_ready = 1'b0;
`ifndef INSTR_FETCH_PREFETCH_EN
        chk("t3_rel_valid", bus.instr_valid, 1'b0);
        chk("t3_rel_addr", bus.mem_addr, 16'h8002);
        chk("t3_rel_rd", bus.mem_rd, 1'b1);
        cyc(1);
`endif
        chk("t3_next_valid", bus.instr_valid, 1'b1);
        chk("t3_next_opcode", bus.opcode, 8'hEA);
        chk("t3_next_ipc", bus.instr_pc, 16'h8002);
        chk("t3_next_pc", pc, 16'h8003);

        // Test 2: stream EA / AD 34 12 / EA with instr_ready tied high.
        mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'hAD; mem[16'h8002] = 8'h34;
        mem[16'h8003] = 8'h12; mem[16'h8004] = 8'hEA;
        reset_dut(1'b0);
        bus.instr_ready = 1'b1;
        got = 0;
        rd_in_hold = 1'b0;
        for (int c = 1; c <= 30 && got < 3; c++) begin
            cyc(1);
            if (bus.instr_valid && bus.mem_rd) rd_in_hold = 1'b1;
            if (bus.instr_valid && bus.instr_ready) begin
                chk("t2_cycle", c, e_cyc[got]);
                chk("t2_opcode", bus.opcode, e_op[got]);
                chk("t2_operand", bus.operand, e_opr[got]);
                chk("t2_ipc", bus.instr_pc, e_ipc[got]);
                got++;
            end
        end
        chk("t2_count", got, 3);
`ifndef INSTR_FETCH_PREFETCH_EN
        chk("t2_no_hold_rd", rd_in_hold, 1'b0);
`endif
        bus.instr_ready = 1'b0;

        // Test 4: three wait states during OPR1.
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        reset_dut(1'b0);
        cyc(3);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t4_wait_addr", bus.mem_addr, 16'h8001);
            chk("t4_wait_valid", bus.instr_valid, 1'b0);
        end
        bus.mem_ready = 1'b1;
        cyc(1);
        chk("t4_valid", bus.instr_valid, 1'b1);
        chk("t4_result", {bus.opcode, bus.operand, bus.instr_pc}, 40'hA9_0042_8000);
        chk("t4_pc", pc, 16'h8002);

        // Test 5: redirect during OPR2 discards the partial instruction.
        mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        mem[16'hC000] = 8'hEA;
        reset_dut(1'b0);
        cyc(4);
        chk("t5_opr2_addr", bus.mem_addr, 16'h8002);
        pc_load = 1'b1; pc_load_val = 16'hC000;
        cyc(1);
        pc_load = 1'b0;
        chk("t5_ld_valid", bus.instr_valid, 1'b0);
        chk("t5_ld_addr", bus.mem_addr, 16'hC000);
        cyc(1);
        chk("t5_valid", bus.instr_valid, 1'b1);
        chk("t5_result", {bus.opcode, bus.operand, bus.instr_pc}, 40'hEA_0000_C000);
        chk("t5_pc", pc, 16'hC001);

        // Test 6: 3-byte instruction at FFFF wraps operand reads to 0000.
        mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF; mem[16'hFFFF] = 8'h4C;
        mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h90;
        reset_dut(1'b0);
        cyc(3);
        chk("t6_wrap_addr", bus.mem_addr, 16'h0000);
        cyc(2);
        chk("t6_valid", bus.instr_valid, 1'b1);
        chk("t6_result", {bus.opcode, bus.operand, bus.instr_pc}, 40'h4C_9000_FFFF);
        chk("t6_pc", pc, 16'h0002);

        // Test 7: reset mid-instruction returns to reset values immediately.
        cyc(1);
        rst = 1'b1;
        #1;
        chk("t7_rst_pc", pc, 16'h0000);
        chk("t7_rst_valid", bus.instr_valid, 1'b0);
        chk("t7_rst_opcode", bus.opcode, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
